// File: rtl/axi_write_order_buffer.sv
// axi_write_order_buffer: restores sequence order of AXI write bursts.
// A burst whose awuser matches exp_seq passes straight through; any other
// burst is parked in a slot and replayed once its sequence comes up.
// Handshakes: a transfer happens on a rising edge where valid && ready.
// Once this block raises m_awvalid/m_wvalid it holds it, with a stable
// payload, until that transfer happens. Upstream W beats follow AW order.
module axi_write_order_buffer #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int ID_W       = 4,
  parameter int SEQ_W      = 4,
  parameter int BUF_BURSTS = 4,
  parameter int MAX_BEATS  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          s_awvalid,
  output logic                          s_awready,
  input  logic [ID_W-1:0]               s_awid,
  input  logic [ADDR_W-1:0]             s_awaddr,
  input  logic [7:0]                    s_awlen,
  input  logic [2:0]                    s_awsize,
  input  logic [1:0]                    s_awburst,
  input  logic [SEQ_W-1:0]              s_awuser,
  input  logic                          s_wvalid,
  output logic                          s_wready,
  input  logic [DATA_W-1:0]             s_wdata,
  input  logic [DATA_W/8-1:0]           s_wstrb,
  input  logic                          s_wlast,
  output logic                          m_awvalid,
  input  logic                          m_awready,
  output logic [ID_W-1:0]               m_awid,
  output logic [ADDR_W-1:0]             m_awaddr,
  output logic [7:0]                    m_awlen,
  output logic [2:0]                    m_awsize,
  output logic [1:0]                    m_awburst,
  output logic [SEQ_W-1:0]              m_awuser,
  output logic                          m_wvalid,
  input  logic                          m_wready,
  output logic [DATA_W-1:0]             m_wdata,
  output logic [DATA_W/8-1:0]           m_wstrb,
  output logic                          m_wlast,
  output logic [SEQ_W-1:0]              exp_seq,
  output logic [$clog2(BUF_BURSTS+1)-1:0] buf_count,
  output logic                          stall,
  output logic                          len_err,
  output logic [2:0]                    state_dbg
);

  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(BUF_BURSTS + 1);
  localparam int SL_W   = (BUF_BURSTS > 1) ? $clog2(BUF_BURSTS) : 1;
  localparam int BI_W   = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam logic [8:0] MAX_BEATS_C = 9'(MAX_BEATS);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PASS_W   = 3'd1,
    CAP_W    = 3'd2,
    DRAIN_AW = 3'd3,
    DRAIN_W  = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [BUF_BURSTS-1:0] slot_vld;
  logic [SEQ_W-1:0]      slot_seq   [BUF_BURSTS];
  logic [ID_W-1:0]       slot_id    [BUF_BURSTS];
  logic [ADDR_W-1:0]     slot_addr  [BUF_BURSTS];
  logic [7:0]            slot_len   [BUF_BURSTS];
  logic [2:0]            slot_size  [BUF_BURSTS];
  logic [1:0]            slot_burst [BUF_BURSTS];
  logic [DATA_W-1:0]     mem_data   [BUF_BURSTS][MAX_BEATS];
  logic [STRB_W-1:0]     mem_strb   [BUF_BURSTS][MAX_BEATS];

  logic [SL_W-1:0] cur_slot;
  logic [8:0]      beat_cnt;   // wide enough for 256 beats plus saturation
  logic            hit, free_found, aw_cap;
  logic [SL_W-1:0] hit_idx, free_idx;
  logic [8:0]      len_p1, drain_n;
  logic            last_beat;

  assign state_dbg = state;

  // Lowest-index slot holding exp_seq, and lowest-index free slot.
  always_comb begin
    hit        = 1'b0;
    hit_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = BUF_BURSTS - 1; i >= 0; i--) begin
      if (slot_vld[i] && (slot_seq[i] == exp_seq)) begin
        hit     = 1'b1;
        hit_idx = SL_W'(i);
      end
      if (!slot_vld[i]) begin
        free_found = 1'b1;
        free_idx   = SL_W'(i);
      end
    end
  end

  // Number of beats replayed from the current slot; beats past MAX_BEATS were never stored.
  always_comb begin
    len_p1    = {1'b0, slot_len[cur_slot]} + 9'd1;
    drain_n   = (len_p1 > MAX_BEATS_C) ? MAX_BEATS_C : len_p1;
    last_beat = (beat_cnt == (drain_n - 9'd1));
  end

  // Next-state logic and all handshake / payload outputs.
  always_comb begin
    state_nxt = state;
    s_awready = 1'b0;
    s_wready  = 1'b0;
    stall     = 1'b0;
    aw_cap    = 1'b0;
    m_awvalid = 1'b0;
    m_awid    = s_awid;
    m_awaddr  = s_awaddr;
    m_awlen   = s_awlen;
    m_awsize  = s_awsize;
    m_awburst = s_awburst;
    m_awuser  = s_awuser;
    m_wvalid  = 1'b0;
    m_wdata   = s_wdata;
    m_wstrb   = s_wstrb;
    m_wlast   = s_wlast;
    case (state)
      IDLE: begin
        if (hit) begin
          state_nxt = DRAIN_AW;
        end else if (s_awvalid && (s_awuser == exp_seq)) begin
          m_awvalid = 1'b1;
          s_awready = m_awready;
          if (m_awready) state_nxt = PASS_W;
        end else if (s_awvalid && free_found) begin
          s_awready = 1'b1;
          aw_cap    = 1'b1;
          state_nxt = CAP_W;
        end else if (s_awvalid) begin
          stall = 1'b1;
        end
      end
      PASS_W: begin
        m_wvalid = s_wvalid;
        s_wready = m_wready;
        if (s_wvalid && m_wready && s_wlast) state_nxt = IDLE;
      end
      CAP_W: begin
        s_wready = 1'b1;
        if (s_wvalid && s_wlast) state_nxt = IDLE;
      end
      DRAIN_AW: begin
        m_awvalid = 1'b1;
        m_awid    = slot_id[cur_slot];
        m_awaddr  = slot_addr[cur_slot];
        m_awlen   = slot_len[cur_slot];
        m_awsize  = slot_size[cur_slot];
        m_awburst = slot_burst[cur_slot];
        m_awuser  = slot_seq[cur_slot];
        if (m_awready) state_nxt = DRAIN_W;
      end
      DRAIN_W: begin
        m_wvalid = 1'b1;
        m_wdata  = mem_data[cur_slot][beat_cnt[BI_W-1:0]];
        m_wstrb  = mem_strb[cur_slot][beat_cnt[BI_W-1:0]];
        m_wlast  = last_beat;
        if (m_wready && last_beat) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control state: FSM, slot occupancy, beat counter, sequence and error tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      slot_vld  <= '0;
      exp_seq   <= '0;
      buf_count <= '0;
      len_err   <= 1'b0;
      cur_slot  <= '0;
      beat_cnt  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          beat_cnt <= '0;
          if (hit) cur_slot <= hit_idx;
          else if (aw_cap) cur_slot <= free_idx;
        end
        PASS_W: begin
          if (s_wvalid && m_wready && s_wlast) exp_seq <= exp_seq + SEQ_W'(1);
        end
        CAP_W: begin
          if (s_wvalid) begin
            if (beat_cnt >= MAX_BEATS_C) len_err <= 1'b1;
            if (beat_cnt != '1) beat_cnt <= beat_cnt + 9'd1;
            if (s_wlast) begin
              slot_vld[cur_slot] <= 1'b1;
              buf_count          <= buf_count + CNT_W'(1);
              beat_cnt           <= '0;
            end
          end
        end
        DRAIN_W: begin
          if (m_wready) begin
            beat_cnt <= beat_cnt + 9'd1;
            if (last_beat) begin
              slot_vld[cur_slot] <= 1'b0;
              buf_count          <= buf_count - CNT_W'(1);
              exp_seq            <= exp_seq + SEQ_W'(1);
              beat_cnt           <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Slot payload storage; contents are only meaningful while the slot is valid.
  always_ff @(posedge clk) begin
    if ((state == IDLE) && !hit && aw_cap) begin
      slot_seq[free_idx]   <= s_awuser;
      slot_id[free_idx]    <= s_awid;
      slot_addr[free_idx]  <= s_awaddr;
      slot_len[free_idx]   <= s_awlen;
      slot_size[free_idx]  <= s_awsize;
      slot_burst[free_idx] <= s_awburst;
    end
    if ((state == CAP_W) && s_wvalid && (beat_cnt < MAX_BEATS_C)) begin
      mem_data[cur_slot][beat_cnt[BI_W-1:0]] <= s_wdata;
      mem_strb[cur_slot][beat_cnt[BI_W-1:0]] <= s_wstrb;
    end
  end

endmodule
